regfile_wb_sequencer: RTL and testbench

//  Serialises SEQ writeback onto the single register-file write port.

---
 rtl/regfile_wb_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_regfile_wb_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sequencer.sv
// Serialises SEQ writeback (E then M) onto the single register-file write port.
// Optional debug write port enabled by defining REGFILE_DBG_PORT_EN.
module regfile_wb_sequencer #(
  parameter int unsigned NREG  = 15,
  parameter logic [3:0]  RNONE = 4'hF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [3:0]       wb_dstE,
  input  logic [63:0]      wb_valE,
  input  logic [3:0]       wb_dstM,
  input  logic [63:0]      wb_valM,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [63:0]      rf_wdata,
  output logic             pend_valid,
  output logic [NREG-1:0]  pend_mask,
  output logic [CNT_W-1:0] wr_cnt
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic             dbg_req,
  input  logic [3:0]       dbg_addr,
  input  logic [63:0]      dbg_data,
  output logic             dbg_ack
`endif
);

`ifdef REGFILE_DBG_PORT_EN
  typedef enum logic [1:0] {IDLE, WR_E, WR_M, DBG} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR_E, WR_M} state_t;
`endif

  state_t state_q, state_d;
  logic [3:0]       e_addr_q, e_addr_d, m_addr_q, m_addr_d;
  logic [63:0]      e_data_q, e_data_d, m_data_q, m_data_d;
  logic             m_live_q, m_live_d;
  logic             rf_we_q, rf_we_d;
  logic [3:0]       rf_waddr_q, rf_waddr_d;
  logic [63:0]      rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]  pend_q, pend_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
`ifdef REGFILE_DBG_PORT_EN
  logic             dbg_ack_q, dbg_ack_d;
`endif

  function automatic logic live(input logic [3:0] d);
    return (d != RNONE) && (32'(d) < NREG);
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [3:0] d);
    return NREG'(1) << d;
  endfunction

`ifdef REGFILE_DBG_PORT_EN
  assign wb_ready = ready_q && !(state_q == IDLE && dbg_req);
  assign dbg_ack  = dbg_ack_q;
`else
  assign wb_ready = ready_q;
`endif
  assign accept     = wb_valid && wb_ready;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pend_mask  = pend_q;
  assign pend_valid = |pend_q;
  assign wr_cnt     = cnt_q;

  always_comb begin
    state_d  = state_q;
    e_addr_d = e_addr_q;
    e_data_d = e_data_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    m_live_d = m_live_q;
    if (state_q == WR_E && m_live_q) begin
      state_d = WR_M;
`ifdef REGFILE_DBG_PORT_EN
    end else if (state_q == DBG) begin
      state_d = IDLE;
    end else if (state_q == IDLE && dbg_req) begin
      // Debug payload reuses the E latch; it is never live alongside a wb request.
      state_d  = DBG;
      e_addr_d = dbg_addr;
      e_data_d = dbg_data;
      m_live_d = 1'b0;
`endif
    end else if (accept) begin
      e_addr_d = wb_dstE;
      e_data_d = wb_valE;
      m_addr_d = wb_dstM;
      m_data_d = wb_valM;
      m_live_d = live(wb_dstM);
      if (live(wb_dstE))      state_d = WR_E;
      else if (live(wb_dstM)) state_d = WR_M;
      else                    state_d = IDLE;
    end else begin
      state_d = IDLE;
    end

    // Outputs are precomputed from the next state so they leave straight from flops.
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    pend_d     = '0;
    ready_d    = 1'b0;
    case (state_d)
      IDLE: ready_d = 1'b1;
      WR_E: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = e_addr_d;
        rf_wdata_d = e_data_d;
        pend_d     = onehot(e_addr_d) | (m_live_d ? onehot(m_addr_d) : '0);
        ready_d    = !m_live_d;
      end
      WR_M: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = m_addr_d;
        rf_wdata_d = m_data_d;
        pend_d     = onehot(m_addr_d);
        ready_d    = 1'b1;
      end
`ifdef REGFILE_DBG_PORT_EN
      DBG: begin
        if (live(e_addr_d)) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = e_addr_d;
          rf_wdata_d = e_data_d;
        end
      end
`endif
      default: ;
    endcase
`ifdef REGFILE_DBG_PORT_EN
    dbg_ack_d = (state_d == DBG);
`endif
    cnt_d = cnt_q + CNT_W'(rf_we_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      e_addr_q   <= '0;
      e_data_q   <= '0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      m_live_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pend_q     <= '0;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
`ifdef REGFILE_DBG_PORT_EN
      dbg_ack_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      e_addr_q   <= e_addr_d;
      e_data_q   <= e_data_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
      m_live_q   <= m_live_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
`ifdef REGFILE_DBG_PORT_EN
      dbg_ack_q  <= dbg_ack_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed cycle-table bench for regfile_wb_sequencer (default build, no debug port).
module tb_regfile_wb_sequencer;

  logic        clk, rst_n, wb_valid, wb_ready;
  logic [3:0]  wb_dstE, wb_dstM, rf_waddr;
  logic [63:0] wb_valE, wb_valM, rf_wdata;
  logic        rf_we, pend_valid;
  logic [14:0] pend_mask;
  logic [15:0] wr_cnt;

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [63:0] mreg [15];

  regfile_wb_sequencer #(.NREG(15), .RNONE(4'hF), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_mask(pend_mask), .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic        rdy;
    logic        we;
    logic [3:0]  wa;
    logic [63:0] wd;
    logic [14:0] pend;
    logic [15:0] cnt;
  } row_t;

  row_t tbl [18];

  function automatic row_t mk(input logic v, input logic [3:0] de, input logic [63:0] ve,
                              input logic [3:0] dm, input logic [63:0] vm,
                              input logic rdy, input logic we, input logic [3:0] wa,
                              input logic [63:0] wd, input logic [14:0] pend,
                              input logic [15:0] cnt);
    row_t r;
    r.v = v; r.de = de; r.ve = ve; r.dm = dm; r.vm = vm;
    r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd; r.pend = pend; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  initial begin
    // idle rows carry zero payload with RNONE destinations
    tbl[0]  = mk(1'b1, 4'h3, 64'h2A,  4'hF, 64'h0,  1'b1, 1'b0, 4'h0, 64'h0,   15'h0000, 16'd0);
    tbl[1]  = mk(1'b0, 4'hF, 64'h0,   4'hF, 64'h0,  1'b1, 1'b1, 4'h3, 64'h2A,  15'h0008, 16'd0);
    tbl[2]  = mk(1'b1, 4'h4, 64'h408, 4'h2, 64'h55, 1'b1, 1'b0, 4'h0, 64'h0,   15'h0000, 16'd1);
    tbl[3]  = mk(1'b1, 4'h4, 64'h3F8, 4'h4, 64'h77, 1'b0, 1'b1, 4'h4, 64'h408, 15'h0014, 16'd1);
    tbl[4]  = mk(1'b1, 4'h4, 64'h3F8, 4'h4, 64'h77, 1'b1, 1'b1, 4'h2, 64'h55,  15'h0004, 16'd2);
    tbl[5]  = mk(1'b0, 4'hF, 64'h0,   4'hF, 64'h0,  1'b0, 1'b1, 4'h4, 64'h3F8, 15'h0010, 16'd3);
    tbl[6]  = mk(1'b0, 4'hF, 64'h0,   4'hF, 64'h0,  1'b1, 1'b1, 4'h4, 64'h77,  15'h0010, 16'd4);
    tbl[7]  = mk(1'b1, 4'h1, 64'h11,  4'hF, 64'h0,  1'b1, 1'b0, 4'h0, 64'h0,   15'h0000, 16'd5);
    tbl[8]  = mk(1'b1, 4'hF, 64'h0,   4'h5, 64'h22, 1'b1, 1'b1, 4'h1, 64'h11,  15'h0002, 16'd5);
    tbl[9]  = mk(1'b1, 4'h6, 64'h33,  4'hF, 64'h0,  1'b1, 1'b1, 4'h5, 64'h22,  15'h0020, 16'd6);
    tbl[10] = mk(1'b1, 4'hE, 64'h44,  4'hF, 64'h0,  1'b1, 1'b1, 4'h6, 64'h33,  15'h0040, 16'd7);
    tbl[11] = mk(1'b1, 4'hF, 64'h0,   4'hF, 64'h0,  1'b1, 1'b1, 4'hE, 64'h44,  15'h4000, 16'd8);
    tbl[12] = mk(1'b1, 4'h0, 64'h99,  4'hF, 64'h0,  1'b1, 1'b0, 4'h0, 64'h0,   15'h0000, 16'd9);
    tbl[13] = mk(1'b0, 4'hF, 64'h0,   4'hF, 64'h0,  1'b1, 1'b1, 4'h0, 64'h99,  15'h0001, 16'd9);
    tbl[14] = mk(1'b1, 4'h7, 64'h70,  4'h8, 64'h80, 1'b1, 1'b0, 4'h0, 64'h0,   15'h0000, 16'd10);
    tbl[15] = mk(1'b0, 4'hF, 64'h0,   4'hF, 64'h0,  1'b0, 1'b1, 4'h7, 64'h70,  15'h0180, 16'd10);
    tbl[16] = mk(1'b0, 4'hF, 64'h0,   4'hF, 64'h0,  1'b1, 1'b1, 4'h8, 64'h80,  15'h0100, 16'd11);
    tbl[17] = mk(1'b0, 4'hF, 64'h0,   4'hF, 64'h0,  1'b1, 1'b0, 4'h0, 64'h0,   15'h0000, 16'd12);
    for (int i = 0; i < 15; i++) mreg[i] = '0;

    // Reset held with a request pending
    rst_n = 1'b0; wb_valid = 1'b1;
    wb_dstE = 4'h3; wb_valE = 64'h2A; wb_dstM = 4'hF; wb_valM = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", i, 64'(wb_ready), 64'h0);
      chk("rst_we", i, 64'(rf_we), 64'h0);
      chk("rst_cnt", i, 64'(wr_cnt), 64'h0);
    end
    chk("rst_pend", 0, 64'(pend_mask), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 0, 64'(wb_ready), 64'h1);

    for (int i = 0; i < 18; i++) begin
      wb_valid = tbl[i].v;
      wb_dstE = tbl[i].de; wb_valE = tbl[i].ve;
      wb_dstM = tbl[i].dm; wb_valM = tbl[i].vm;
      @(negedge clk);
      chk("ready", i, 64'(wb_ready), 64'(tbl[i].rdy));
      chk("we", i, 64'(rf_we), 64'(tbl[i].we));
      chk("waddr", i, 64'(rf_waddr), 64'(tbl[i].wa));
      chk("wdata", i, rf_wdata, tbl[i].wd);
      chk("pend_mask", i, 64'(pend_mask), 64'(tbl[i].pend));
      chk("pend_valid", i, 64'(pend_valid), 64'(|tbl[i].pend));
      chk("wr_cnt", i, 64'(wr_cnt), 64'(tbl[i].cnt));
      if (rf_we && rf_waddr < 4'hF) mreg[rf_waddr] = rf_wdata;
      @(posedge clk); #1;
    end
    chk("reg4_final", 0, mreg[4], 64'h77);
    chk("reg2_final", 0, mreg[2], 64'h55);
    chk("reg14_final", 0, mreg[14], 64'h44);

    // Async reset in the middle of the E write of a dual request
    wb_valid = 1'b1;
    wb_dstE = 4'h9; wb_valE = 64'h90; wb_dstM = 4'hA; wb_valM = 64'hA0;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    #1;
    chk("mid_we", 0, 64'(rf_we), 64'h1);
    chk("mid_waddr", 0, 64'(rf_waddr), 64'h9);
    chk("mid_pend", 0, 64'(pend_mask), 64'h0600);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 0, 64'(rf_we), 64'h0);
    chk("arst_pend", 0, 64'(pend_mask), 64'h0);
    chk("arst_pvalid", 0, 64'(pend_valid), 64'h0);
    chk("arst_cnt", 0, 64'(wr_cnt), 64'h0);
    chk("arst_ready", 0, 64'(wb_ready), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_m_write", i, 64'(rf_we), 64'h0);
      chk("post_pend", i, 64'(pend_mask), 64'h0);
    end
    chk("post_cnt", 0, 64'(wr_cnt), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
